// File: rtl/iopmp_entry_mem_arbiter_if.sv
// Bus bundle for the IOPMP entry table arbiter.
// Groups the configuration, lookup and memory sides.
interface iopmp_entry_mem_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int NumWords  = 64,
    parameter int DataWidth = 64,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic                                cfg_req_i;
    logic                                cfg_we_i;
    logic [AddrWidth-1:0]                cfg_addr_i;
    logic [DataWidth-1:0]                cfg_wdata_i;
    logic [DataWidth/8-1:0]              cfg_be_i;
    logic                                cfg_lock_i;
    logic                                cfg_gnt_o;
    logic                                cfg_rvalid_o;
    logic [DataWidth-1:0]                cfg_rdata_o;

    logic [NumReq-1:0]                   lk_req_i;
    logic [NumReq-1:0][AddrWidth-1:0]    lk_addr_i;
    logic [NumReq-1:0]                   lk_gnt_o;
    logic                                lk_rvalid_o;
    logic [IdxWidth-1:0]                 lk_rid_o;
    logic [DataWidth-1:0]                lk_rdata_o;

    logic [1:0]                          mem_req_o;
    logic [1:0]                          mem_we_o;
    logic [1:0][AddrWidth-1:0]           mem_addr_o;
    logic [1:0][DataWidth-1:0]           mem_wdata_o;
    logic [1:0][DataWidth/8-1:0]         mem_be_o;
    logic [1:0][DataWidth-1:0]           mem_rdata_i;

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_be_i, cfg_lock_i, lk_req_i, lk_addr_i, mem_rdata_i,
        output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
        output lk_gnt_o, lk_rvalid_o, lk_rid_o, lk_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cfg_be_i, cfg_lock_i, lk_req_i, lk_addr_i, mem_rdata_i,
        input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
        input  lk_gnt_o, lk_rvalid_o, lk_rid_o, lk_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/iopmp_entry_mem_arbiter.sv
// IOPMP entry table port controller: cfg owns port 0,
// lookups share port 1 round-robin with write hazard hold-off.
module iopmp_entry_mem_arbiter #(
    parameter int NumReq    = 4,
    parameter int NumWords  = 64,
    parameter int DataWidth = 64,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic clk_i,
    input  logic rst_i,
    iopmp_entry_mem_arbiter_if.slave bus
);
    logic [IdxWidth-1:0]  r_rr;
    logic                 r_wp_vld;
    logic [AddrWidth-1:0] r_wp_addr;
    logic                 r_cfg_rvalid;
    logic [DataWidth-1:0] r_cfg_rdata;
    logic                 r_lk_rvalid;
    logic [IdxWidth-1:0]  r_lk_rid;
    logic [DataWidth-1:0] r_lk_rdata;

    logic                 w_found;
    logic [IdxWidth-1:0]  w_win;
    logic [AddrWidth-1:0] w_win_addr;
    logic                 w_cfg_wr;
    logic                 w_hold;
    logic                 w_gnt;
    logic [IdxWidth-1:0]  w_rr_nxt;

    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NumReq; k++) begin
            j = int'(r_rr) + k;
            if (j >= NumReq) j = j - NumReq;
            if (!w_found && bus.lk_req_i[j]) begin
                w_found = 1'b1;
                w_win   = IdxWidth'(j);
            end
        end
    end

    assign w_win_addr = bus.lk_addr_i[w_win];
    assign w_cfg_wr   = bus.cfg_req_i & bus.cfg_we_i;

    // A write is not readable until two cycles later, so hold the winner
    // off rather than hand out another requester in its place.
    assign w_hold = bus.cfg_lock_i
                  | (w_cfg_wr && (bus.cfg_addr_i == w_win_addr))
                  | (r_wp_vld && (r_wp_addr == w_win_addr));
    assign w_gnt  = w_found & ~w_hold;

    assign w_rr_nxt = (w_win == IdxWidth'(NumReq - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        bus.cfg_gnt_o      = bus.cfg_req_i;
        bus.lk_gnt_o       = w_gnt ? (NumReq'(1) << w_win) : '0;
        bus.mem_req_o      = {w_gnt, bus.cfg_req_i};
        bus.mem_we_o       = {1'b0, w_cfg_wr};
        bus.mem_addr_o[0]  = bus.cfg_addr_i;
        bus.mem_addr_o[1]  = w_gnt ? w_win_addr : '0;
        bus.mem_wdata_o[0] = bus.cfg_wdata_i;
        bus.mem_wdata_o[1] = '0;
        bus.mem_be_o[0]    = bus.cfg_be_i;
        bus.mem_be_o[1]    = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr         <= '0;
            r_wp_vld     <= 1'b0;
            r_wp_addr    <= '0;
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
            r_lk_rvalid  <= 1'b0;
            r_lk_rid     <= '0;
            r_lk_rdata   <= '0;
        end else begin
            if (w_gnt) r_rr <= w_rr_nxt;
            r_wp_vld     <= w_cfg_wr;
            r_wp_addr    <= bus.cfg_addr_i;
            r_cfg_rvalid <= bus.cfg_req_i;
            if (bus.cfg_req_i) begin
                r_cfg_rdata <= bus.cfg_we_i ? '0 : bus.mem_rdata_i[0];
            end
            r_lk_rvalid  <= w_gnt;
            if (w_gnt) begin
                r_lk_rid   <= w_win;
                r_lk_rdata <= bus.mem_rdata_i[1];
            end
        end
    end

    assign bus.cfg_rvalid_o = r_cfg_rvalid;
    assign bus.cfg_rdata_o  = r_cfg_rdata;
    assign bus.lk_rvalid_o  = r_lk_rvalid;
    assign bus.lk_rid_o     = r_lk_rid;
    assign bus.lk_rdata_o   = r_lk_rdata;
endmodule

// File: tb/tb_iopmp_entry_mem_arbiter.sv
// Bench for iopmp_entry_mem_arbiter: delayed-commit memory,
// reference model checked every cycle, plus directed literal checks.
module tb_iopmp_entry_mem_arbiter;
    localparam int NR = 4;
    localparam int NW = 64;
    localparam int DW = 64;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    iopmp_entry_mem_arbiter_if #(.NumReq(NR), .NumWords(NW), .DataWidth(DW)) bus();

    iopmp_entry_mem_arbiter #(.NumReq(NR), .NumWords(NW), .DataWidth(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d, logic [7:0] be);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ev(int a);
        return {32'hC0DE_0000 + 32'(a), 32'h1234_5600 + 32'(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Latch-style table: a write becomes readable two cycles later.
    logic [63:0] tb_mem [NW];
    logic        stg_v;
    logic [5:0]  stg_a;
    logic [63:0] stg_d;
    logic [7:0]  stg_be;

    always @(posedge clk) begin
        if (stg_v) tb_mem[stg_a] <= merge(tb_mem[stg_a], stg_d, stg_be);
        stg_v  <= bus.mem_req_o[0] & bus.mem_we_o[0];
        stg_a  <= bus.mem_addr_o[0];
        stg_d  <= bus.mem_wdata_o[0];
        stg_be <= bus.mem_be_o[0];
    end

    assign bus.mem_rdata_i[0] = tb_mem[bus.mem_addr_o[0]];
    assign bus.mem_rdata_i[1] = tb_mem[bus.mem_addr_o[1]];

    // Reference model
    typedef struct {
        int          c;
        logic [5:0]  a;
        logic [63:0] d;
        logic [7:0]  be;
    } wr_t;

    wr_t         pend[$];
    logic [63:0] ref_mem [NW];
    int          last_wr [NW];
    int          cyc;
    int          rr;
    logic        e_lkv;
    int          e_rid;
    logic [63:0] e_lkd;
    logic        e_cv;
    logic [63:0] e_cd;

    initial begin
        cyc = 0;
        rr  = 0;
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = '0;
            last_wr[i] = -10;
        end
    end

    always @(negedge clk) begin
        int       win;
        logic     blk;
        logic     cw;
        logic [3:0] eg;
        if (rst) begin
            rr    = 0;
            e_lkv = 0;
            e_rid = 0;
            e_lkd = '0;
            e_cv  = 0;
            e_cd  = '0;
            for (int i = 0; i < NW; i++) last_wr[i] = -10;
        end
        chk("lk_rvalid", 64'(bus.lk_rvalid_o), 64'(e_lkv));
        chk("lk_rid", 64'(bus.lk_rid_o), 64'(e_rid));
        chk("lk_rdata", bus.lk_rdata_o, e_lkd);
        chk("cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'(e_cv));
        chk("cfg_rdata", bus.cfg_rdata_o, e_cd);

        while (pend.size() > 0 && pend[0].c <= cyc - 2) begin
            ref_mem[pend[0].a] = merge(ref_mem[pend[0].a], pend[0].d, pend[0].be);
            void'(pend.pop_front());
        end

        win = -1;
        for (int k = 0; k < NR; k++)
            if (win < 0 && bus.lk_req_i[(rr + k) % NR]) win = (rr + k) % NR;
        cw  = bus.cfg_req_i && bus.cfg_we_i;
        blk = bus.cfg_lock_i;
        if (win >= 0) begin
            if (cw && bus.cfg_addr_i == bus.lk_addr_i[win]) blk = 1;
            if (cyc - last_wr[bus.lk_addr_i[win]] == 1) blk = 1;
        end
        eg = (win >= 0 && !blk) ? 4'(1 << win) : 4'b0;

        chk("lk_gnt", 64'(bus.lk_gnt_o), 64'(eg));
        chk("cfg_gnt", 64'(bus.cfg_gnt_o), 64'(bus.cfg_req_i));
        chk("mem_req", 64'(bus.mem_req_o), 64'({eg != 0, bus.cfg_req_i}));
        chk("mem_we1", 64'(bus.mem_we_o[1]), 64'(0));
        chk("mem_p1_tie", {bus.mem_wdata_o[1][55:0], bus.mem_be_o[1]}, 64'(0));
        if (eg != 0)
            chk("mem_addr1", 64'(bus.mem_addr_o[1]), 64'(bus.lk_addr_i[win]));
        if (bus.cfg_req_i) begin
            chk("mem_we0", 64'(bus.mem_we_o[0]), 64'(bus.cfg_we_i));
            chk("mem_addr0", 64'(bus.mem_addr_o[0]), 64'(bus.cfg_addr_i));
            chk("mem_wdata0", bus.mem_wdata_o[0], bus.cfg_wdata_i);
            chk("mem_be0", 64'(bus.mem_be_o[0]), 64'(bus.cfg_be_i));
        end

        if (!rst) begin
            e_lkv = (eg != 0);
            if (eg != 0) begin
                rr    = (win + 1) % NR;
                e_rid = win;
                e_lkd = ref_mem[bus.lk_addr_i[win]];
            end
            e_cv = bus.cfg_req_i;
            if (bus.cfg_req_i) e_cd = bus.cfg_we_i ? 64'(0) : ref_mem[bus.cfg_addr_i];
            if (cw) begin
                last_wr[bus.cfg_addr_i] = cyc;
                pend.push_back('{cyc, bus.cfg_addr_i, bus.cfg_wdata_i, bus.cfg_be_i});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input logic rq, input logic we, input int a,
                           input logic [63:0] d, input logic [7:0] be);
        bus.cfg_req_i   = rq;
        bus.cfg_we_i    = we;
        bus.cfg_addr_i  = 6'(a);
        bus.cfg_wdata_i = d;
        bus.cfg_be_i    = be;
    endtask

    initial begin
        logic [63:0] fair_d [4];
        n_tests = 0;
        n_fail  = 0;
        fair_d[0] = 64'hC0DE_0001_1234_5601;
        fair_d[1] = 64'hC0DE_0002_1234_5602;
        fair_d[2] = 64'hC0DE_0003_1234_5603;
        fair_d[3] = 64'hC0DE_0004_1234_5604;
        rst = 1'b1;
        cfg_set(0, 0, 0, 0, 0);
        bus.cfg_lock_i = 1'b0;
        bus.lk_req_i   = '0;
        bus.lk_addr_i  = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {bus.lk_gnt_o, bus.mem_req_o, 1'b0, bus.cfg_gnt_o}, 64'(0));
        chk("idle_rv", {bus.lk_rvalid_o, bus.cfg_rvalid_o}, 64'(0));
        chk("idle_rdata", bus.lk_rdata_o | bus.cfg_rdata_o, 64'(0));

        for (int a = 0; a < NW; a++) begin
            tick();
            cfg_set(1, 1, a, ev(a), 8'hFF);
        end
        tick();
        cfg_set(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Fairness
        bus.lk_req_i = 4'hF;
        for (int i = 0; i < NR; i++) bus.lk_addr_i[i] = 6'(i + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fair_gnt", 64'(bus.lk_gnt_o), 64'(1 << (k % 4)));
            if (k > 0) begin
                chk("fair_rid", 64'(bus.lk_rid_o), 64'((k - 1) % 4));
                chk("fair_rdata", bus.lk_rdata_o, fair_d[(k - 1) % 4]);
            end
            tick();
        end
        bus.lk_req_i = '0;
        @(negedge clk);
        chk("fair_rid4", 64'(bus.lk_rid_o), 64'(0));
        chk("fair_rdata4", bus.lk_rdata_o, fair_d[0]);

        // Write/lookup hazard
        tick();
        cfg_set(1, 1, 5, 64'hDEAD_BEEF, 8'hFF);
        bus.lk_req_i     = 4'b0100;
        bus.lk_addr_i[2] = 6'd5;
        @(negedge clk);
        chk("haz_t0", 64'(bus.lk_gnt_o), 64'(0));
        tick();
        cfg_set(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("haz_t1", 64'(bus.lk_gnt_o), 64'(0));
        tick();
        @(negedge clk);
        chk("haz_t2", 64'(bus.lk_gnt_o), 64'(4));
        tick();
        bus.lk_req_i = '0;
        @(negedge clk);
        chk("haz_rv", 64'(bus.lk_rvalid_o), 64'(1));
        chk("haz_rid", 64'(bus.lk_rid_o), 64'(2));
        chk("haz_rdata", bus.lk_rdata_o, 64'hDEAD_BEEF);

        // Bring pointer to 0, then lock
        tick();
        bus.lk_req_i     = 4'b1000;
        bus.lk_addr_i[3] = 6'd9;
        @(negedge clk);
        chk("ptr_gnt3", 64'(bus.lk_gnt_o), 64'(8));
        tick();
        bus.lk_req_i     = 4'b1010;
        bus.lk_addr_i[1] = 6'd10;
        bus.lk_addr_i[3] = 6'd11;
        bus.cfg_lock_i   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lock_gnt", 64'(bus.lk_gnt_o), 64'(0));
            tick();
        end
        bus.cfg_lock_i = 1'b0;
        @(negedge clk);
        chk("unlock_gnt1", 64'(bus.lk_gnt_o), 64'(2));
        tick();
        bus.lk_req_i = 4'b1000;
        @(negedge clk);
        chk("unlock_gnt3", 64'(bus.lk_gnt_o), 64'(8));
        tick();
        bus.lk_req_i = '0;

        // Reset mid-flight
        tick();
        bus.lk_req_i     = 4'b0010;
        bus.lk_addr_i[1] = 6'd12;
        @(negedge clk);
        chk("rmf_gnt", 64'(bus.lk_gnt_o), 64'(2));
        tick();
        rst          = 1'b1;
        bus.lk_req_i = '0;
        @(negedge clk);
        chk("rmf_rv", 64'(bus.lk_rvalid_o), 64'(0));
        tick();
        rst          = 1'b0;
        bus.lk_req_i = 4'hF;
        @(negedge clk);
        chk("rmf_gnt0", 64'(bus.lk_gnt_o), 64'(1));
        chk("rmf_rv2", 64'(bus.lk_rvalid_o), 64'(0));
        tick();
        bus.lk_req_i = '0;

        // Byte-enable write
        tick();
        cfg_set(1, 1, 7, 64'h0, 8'hFF);
        tick();
        cfg_set(1, 1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        @(negedge clk);
        chk("wack_rv", 64'(bus.cfg_rvalid_o), 64'(1));
        chk("wack_rdata", bus.cfg_rdata_o, 64'(0));
        tick();
        cfg_set(0, 0, 0, 0, 0);
        tick();
        tick();
        cfg_set(1, 0, 7, 0, 0);
        tick();
        cfg_set(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("be_rv", 64'(bus.cfg_rvalid_o), 64'(1));
        chk("be_rdata", bus.cfg_rdata_o, 64'h0000_0000_FFFF_FFFF);

        // Random traffic
        repeat (2000) begin
            tick();
            cfg_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom));
            bus.cfg_lock_i = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.lk_req_i[i]  = 1'($urandom_range(0, 1));
                    bus.lk_addr_i[i] = 6'($urandom_range(0, 7));
                end
            end
        end
        tick();
        cfg_set(0, 0, 0, 0, 0);
        bus.cfg_lock_i = 1'b0;
        bus.lk_req_i   = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iopmp_entry_mem_arbiter.md
# iopmp_entry_mem_arbiter

Controller for the IOPMP entry table held in the 2-read/2-write latch memory. Port 0 of the memory is dedicated to the configuration master (read/write). Port 1 is shared round-robin among `NumReq` read-only lookup requesters (checker units). The block orders configuration writes against lookups so that no lookup ever returns a partially written entry. Returned data is registered.

## Interface
- `NumReq`, 4: number of lookup requesters sharing port 1 (≥1).
- `NumWords`, 64: entries in the table.
- `DataWidth`, 64: entry width in bits.
- `AddrWidth`, `$clog2(NumWords)` (1 if `NumWords`=1): derived, do not override.
- `IdxWidth`, `$clog2(NumReq)` (1 if `NumReq`=1): derived, do not override.

Clock, reset and ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `cfg_req_i` in 1: configuration access request.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_addr_i` in AddrWidth: entry index.
- `cfg_wdata_i` in DataWidth: write data.
- `cfg_be_i` in DataWidth/8: byte enables.
- `cfg_lock_i` in 1: blocks all lookup grants while high.
- `cfg_gnt_o` out 1: configuration request accepted.
- `cfg_rvalid_o` out 1: response pulse.
- `cfg_rdata_o` out DataWidth: read data (0 for write acks).
- `lk_req_i` in NumReq: per-requester lookup request.
- `lk_addr_i` in NumReq×AddrWidth: per-requester entry index.
- `lk_gnt_o` out NumReq: one-hot grant.
- `lk_rvalid_o` out 1: lookup response pulse.
- `lk_rid_o` out IdxWidth: requester index for the response.
- `lk_rdata_o` out DataWidth: lookup data.
- `mem_req_o` out 2: memory request, ports 0/1.
- `mem_we_o` out 2: memory write enable; bit 1 is always 0.
- `mem_addr_o` out 2×AddrWidth: memory address.
- `mem_wdata_o` out 2×DataWidth: memory write data; port 1 is tied to 0.
- `mem_be_o` out 2×DataWidth/8: memory byte enables; port 1 is tied to 0.
- `mem_rdata_i` in 2×DataWidth: combinational read data from memory.

## Operation
- **Configuration port**
  - `cfg_gnt_o` = `cfg_req_i`; the configuration master is never stalled.
  - Memory port 0 is driven combinationally from the cfg inputs.
- **Lookup arbitration**
  - Round-robin pointer `rr_q` (IdxWidth bits, reset 0).
  - Candidates are scanned from `rr_q` upward, wrapping at NumReq−1 → 0; the first requester with `lk_req_i` set wins.
- **Grant suppression.** No lookup grant is issued in a cycle if any of these holds:
  - (a) `cfg_lock_i`=1.
  - (b) A cfg write in the same cycle targets the winner's address.
  - (c) The pending-write register `wp_q` is valid and matches the winner's address.
  - When suppressed: `lk_gnt_o`=0, `mem_req_o[1]`=0, `rr_q` unchanged, and no lower-priority requester is substituted that cycle.
- **On a lookup grant to requester i**
  - Drive `mem_req_o[1]`=1 and `mem_addr_o[1]` = `lk_addr_i[i]`.
  - `rr_q` ← (i+1) mod NumReq.
- **Pending write.** `wp_q` ← {valid, addr} of the current cfg write (valid=0 if none). It covers the latch update window: the write becomes readable from cycle t+2.
- **Requester rules**
  - A requester holds `lk_req_i` and `lk_addr_i` stable until granted.
  - Dropping a request before grant is legal; it is simply not granted.
- **Multiple grants.** Several grants to different requesters may be in flight back-to-back, one per cycle.

## Timing
- **Reset values**
  - `cfg_rvalid_o`=0, `cfg_rdata_o`=0.
  - `lk_rvalid_o`=0, `lk_rid_o`=0, `lk_rdata_o`=0.
  - `rr_q`=0, `wp_q` invalid.
  - `cfg_gnt_o`, `lk_gnt_o` and `mem_*` are combinational; with inputs 0 they are 0.
- **Latency:** a request granted in cycle t returns its response in t+1.
  - `*_rvalid_o` is a one-cycle pulse.
  - `*_rdata_o` is `mem_rdata_i` sampled at the end of t and held until the next response.
- **Write ack:** `cfg_rvalid_o` pulses at t+1 with `cfg_rdata_o`=0.
- **Lookup hold-off after a write:** a cfg write to X at t blocks lookups to X in t and t+1. A lookup to X is first grantable in t+2 and returns the new data in t+3.
- **Simultaneous events**
  - A cfg read and a lookup to the same address in the same cycle are both granted.
  - Lock asserted mid-stream: responses already granted still return; new grants stop in the same cycle.
- **Reset mid-operation:** pending responses are discarded (no rvalid after reset) and `rr_q` returns to 0.
- **Throughput:** one cfg access and one lookup per cycle.

## Test plan
- **Reset, then idle:** all requests 0 → all outputs 0, no `mem_req_o`.
- **Fairness:** NumReq=4, all four lookups held on addresses 1,2,3,4 → grants in order 0,1,2,3,0. `lk_rid_o` and `lk_rdata_o` at t+1 match the entry contents.
- **Write/lookup hazard**
  - Stimulus: cfg write 0xDEAD_BEEF to entry 5 at t; requester 2 holds lookup to 5 from t.
  - Required: no grant at t or t+1; grant at t+2; `lk_rdata_o`=0xDEAD_BEEF, `lk_rid_o`=2 at t+3; `rr_q` unchanged during t..t+1.
- **Lock:** `cfg_lock_i` high for 5 cycles with requesters 1 and 3 pending → zero lookup grants. After release, requester 1 is granted the next cycle (pointer=0), then requester 3.
- **Byte-enable write:** entry 7 = 0; write 0xFF..FF with `cfg_be_i`=0x0F → cfg read of entry 7 returns 0x0000_0000_FFFF_FFFF.
- **Reset mid-flight:** grant to requester 1 at t, `rst_i` pulsed during t+1 → no `lk_rvalid_o` after reset, and the next grant goes to requester 0 when all request.
